// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - opcodes, fetch states and sign-extension helpers
package fetch_sequencer_pkg;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_REQ,
    ST_HOLD,
    ST_HALTED
  } fetch_state_t;

  function automatic logic [15:0] sext11(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_target.sv
// rtl/fetch_sequencer_pc_target.sv - execute-stage redirect decision and target address
module pc_target
  import fetch_sequencer_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [15:0] pc2,
  input  logic [10:0] imm,
  input  logic        flag,
  input  logic [15:0] jump,
  output logic        take,
  output logic [15:0] target
);

  always_comb begin
    take   = 1'b0;
    target = pc2 + sext11(imm);
    if (opcode == OP_J || opcode == OP_JAL) begin
      take   = 1'b1;
      target = pc2 + sext11(imm);
    end else if (opcode == OP_JR || opcode == OP_JALR) begin
      take   = 1'b1;
      target = jump;
    end else if (opcode == OP_BEQZ || opcode == OP_BNEZ ||
                 opcode == OP_BLTZ || opcode == OP_BGEZ) begin
      // The ALU has already evaluated the condition; only its verdict matters here.
      take   = flag;
      target = pc2 + sext8(imm[7:0]);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - owns the PC, fetches from imem, hands words to decode, redirects and halts
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [4:0]  HALT_OP  = OP_HALT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst,
  output logic [15:0] inst_pc2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_opcode,
  input  logic [15:0] ex_pc2,
  input  logic [10:0] ex_imm,
  input  logic        ex_flag,
  input  logic [15:0] ex_jump,
  output logic        redirect,
  output logic        halted
);

  fetch_state_t state, state_next;
  logic [15:0]  pc, req_addr, inst_buf, pc2_buf, target;
  logic         squash, take, active, do_redirect, do_halt;

  pc_target u_pc_target (
    .opcode(ex_opcode),
    .pc2   (ex_pc2),
    .imm   (ex_imm),
    .flag  (ex_flag),
    .jump  (ex_jump),
    .take  (take),
    .target(target)
  );

  assign active      = (state == ST_REQ) || (state == ST_HOLD);
  assign do_redirect = active && ex_valid && take;
  assign do_halt     = active && ex_valid && (ex_opcode == HALT_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT: state_next = ST_REQ;
      ST_REQ: begin
        if (!do_redirect) begin
          if (do_halt)                   state_next = ST_HALTED;
          else if (imem_valid && !squash) state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (do_redirect)     state_next = ST_REQ;
        else if (do_halt)    state_next = ST_HALTED;
        else if (inst_ready) state_next = ST_REQ;
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_BOOT;
    endcase
  end

  always_comb begin
    imem_req   = (state == ST_REQ);
    inst_valid = (state == ST_HOLD);
    halted     = (state == ST_HALTED);
    redirect   = do_redirect;
  end

  assign imem_addr = req_addr;
  assign inst      = inst_buf;
  assign inst_pc2  = pc2_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      inst_buf <= 16'h0000;
      pc2_buf  <= RESET_PC + 16'd2;
      squash   <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (do_redirect) begin
            pc <= target;
            // An outstanding request keeps its address; its answer is marked stale.
            if (imem_valid) begin
              req_addr <= target;
              squash   <= 1'b0;
            end else begin
              squash   <= 1'b1;
            end
          end else if (!do_halt && imem_valid) begin
            if (squash) begin
              squash   <= 1'b0;
              req_addr <= pc;
            end else begin
              inst_buf <= imem_data;
              pc2_buf  <= req_addr + 16'd2;
              pc       <= req_addr + 16'd2;
            end
          end
        end
        ST_HOLD: begin
          if (do_redirect) begin
            pc       <= target;
            req_addr <= target;
          end else if (!do_halt && inst_ready) begin
            req_addr <= pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized checks of fetch_sequencer against a behavioural model
module tb_fetch_sequencer;

  localparam logic [4:0] T_HALT = 5'b00000;
  localparam logic [4:0] T_J    = 5'b00100;
  localparam logic [4:0] T_JR   = 5'b00101;
  localparam logic [4:0] T_JAL  = 5'b00110;
  localparam logic [4:0] T_JALR = 5'b00111;
  localparam logic [4:0] T_BNEZ = 5'b01101;

  localparam int P_BOOT = 0, P_FETCH = 1, P_HOLD = 2, P_STOP = 3;

  logic        clk, rst_n;
  logic        imem_req, imem_valid, inst_valid, inst_ready, ex_valid, ex_flag, redirect, halted;
  logic [15:0] imem_addr, imem_data, inst, inst_pc2, ex_pc2, ex_jump;
  logic [4:0]  ex_opcode;
  logic [10:0] ex_imm;

  logic        d_rst_n, d_imem_valid, d_inst_ready, d_ex_valid, d_ex_flag;
  logic [15:0] d_imem_data, d_ex_pc2, d_ex_jump;
  logic [4:0]  d_ex_opcode;
  logic [10:0] d_ex_imm;

  int          checks = 0;
  int          errors = 0;
  int          m_phase;
  logic [15:0] m_pc, m_addr, m_word, m_link;
  bit          m_stale;
  logic        last_redirect, last_req;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc2(inst_pc2),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_pc2(ex_pc2), .ex_imm(ex_imm),
    .ex_flag(ex_flag), .ex_jump(ex_jump), .redirect(redirect), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // {taken, target} from the resolution rules, using signed integer offsets.
  function automatic logic [16:0] model_target(input logic [4:0] op, input logic [15:0] pc2,
                                               input logic [10:0] imm, input logic flag,
                                               input logic [15:0] jump);
    int off;
    if (op == T_J || op == T_JAL) begin
      off = imm[10] ? int'(imm) - 2048 : int'(imm);
      return {1'b1, 16'(int'(pc2) + off)};
    end
    if (op == T_JR || op == T_JALR) return {1'b1, jump};
    if (op[4:2] == 3'b011) begin
      off = imm[7] ? int'(imm[7:0]) - 256 : int'(imm[7:0]);
      return {flag, 16'(int'(pc2) + off)};
    end
    return 17'd0;
  endfunction

  task automatic model_reset();
    m_phase = P_BOOT;
    m_pc    = 16'h0000;
    m_addr  = 16'h0000;
    m_word  = 16'h0000;
    m_link  = 16'h0002;
    m_stale = 1'b0;
  endtask

  function automatic bit model_redirect();
    logic [16:0] t;
    t = model_target(ex_opcode, ex_pc2, ex_imm, ex_flag, ex_jump);
    return (m_phase == P_FETCH || m_phase == P_HOLD) && ex_valid && t[16];
  endfunction

  task automatic model_advance();
    logic [16:0] t;
    bit          redir, stop;
    t     = model_target(ex_opcode, ex_pc2, ex_imm, ex_flag, ex_jump);
    redir = model_redirect();
    stop  = (m_phase == P_FETCH || m_phase == P_HOLD) && ex_valid && ex_opcode == T_HALT;
    if (m_phase == P_BOOT) begin
      m_phase = P_FETCH;
    end else if (m_phase == P_FETCH) begin
      if (redir) begin
        m_pc = t[15:0];
        if (imem_valid) begin m_addr = t[15:0]; m_stale = 1'b0; end
        else m_stale = 1'b1;
      end else if (stop) begin
        m_phase = P_STOP;
      end else if (imem_valid) begin
        if (m_stale) begin m_stale = 1'b0; m_addr = m_pc; end
        else begin
          m_word  = imem_data;
          m_link  = m_addr + 16'd2;
          m_pc    = m_addr + 16'd2;
          m_phase = P_HOLD;
        end
      end
    end else if (m_phase == P_HOLD) begin
      if (redir) begin m_pc = t[15:0]; m_addr = t[15:0]; m_phase = P_FETCH; end
      else if (stop) m_phase = P_STOP;
      else if (inst_ready) begin m_addr = m_pc; m_phase = P_FETCH; end
    end
  endtask

  task automatic compare();
    chk("imem_req",   {15'd0, imem_req},   {15'd0, m_phase == P_FETCH});
    chk("imem_addr",  imem_addr,           m_addr);
    chk("inst_valid", {15'd0, inst_valid}, {15'd0, m_phase == P_HOLD});
    chk("inst",       inst,                m_word);
    chk("inst_pc2",   inst_pc2,            m_link);
    chk("redirect",   {15'd0, redirect},   {15'd0, model_redirect()});
    chk("halted",     {15'd0, halted},     {15'd0, m_phase == P_STOP});
  endtask

  task automatic step();
    @(negedge clk);
    rst_n = d_rst_n; imem_valid = d_imem_valid; imem_data = d_imem_data;
    inst_ready = d_inst_ready; ex_valid = d_ex_valid; ex_opcode = d_ex_opcode;
    ex_pc2 = d_ex_pc2; ex_imm = d_ex_imm; ex_flag = d_ex_flag; ex_jump = d_ex_jump;
    #1;
    if (!rst_n) model_reset();
    compare();
    last_redirect = redirect;
    last_req      = imem_req;
    if (rst_n) model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_imem_valid = 0; d_imem_data = 0; d_inst_ready = 0; d_ex_valid = 0;
    d_ex_opcode = 5'b10000; d_ex_pc2 = 0; d_ex_imm = 0; d_ex_flag = 0; d_ex_jump = 0;
  endtask

  task automatic set_ex(input logic [4:0] op, input logic [15:0] pc2, input logic [10:0] imm,
                        input logic flag, input logic [15:0] jump);
    d_ex_valid = 1; d_ex_opcode = op; d_ex_pc2 = pc2; d_ex_imm = imm; d_ex_flag = flag; d_ex_jump = jump;
  endtask

  initial begin
    logic [16:0] t;
    int          stop_cycles;
    rst_n = 0; imem_valid = 0; imem_data = 0; inst_ready = 0; ex_valid = 0; ex_opcode = 0;
    ex_pc2 = 0; ex_imm = 0; ex_flag = 0; ex_jump = 0;
    d_rst_n = 0;
    idle();
    model_reset();

    t = model_target(T_J, 16'h0010, 11'h7FE, 1'b0, 16'h0000);
    chk("model_j", t[15:0], 16'h000E);
    t = model_target(T_BNEZ, 16'h0004, 11'h080, 1'b1, 16'h0000);
    chk("model_br", t[15:0], 16'hFF84);

    step(); step();
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_pc2", inst_pc2, 16'h0002);

    d_rst_n = 1;
    step();
    chk("t1_boot_req", {15'd0, last_req}, 16'd0);
    chk("t1_req", {15'd0, imem_req}, 16'd1);
    d_imem_valid = 1; d_imem_data = 16'hC123;
    step();
    d_imem_valid = 0;
    chk("t1_inst", inst, 16'hC123);
    chk("t1_pc2", inst_pc2, 16'h0002);

    repeat (3) begin
      step();
      chk("t2_inst", inst, 16'hC123);
      chk("t2_req", {15'd0, imem_req}, 16'd0);
    end
    d_inst_ready = 1;
    step();
    d_inst_ready = 0;
    chk("t2_addr", imem_addr, 16'h0002);
    d_imem_valid = 1; d_imem_data = 16'h1111;
    step();
    d_imem_valid = 0;

    set_ex(T_J, 16'h0010, 11'h7FE, 1'b0, 16'h0000);
    step();
    idle();
    chk("t3_redirect", {15'd0, last_redirect}, 16'd1);
    chk("t3_addr", imem_addr, 16'h000E);
    step();
    chk("t3_pulse", {15'd0, last_redirect}, 16'd0);

    set_ex(T_JR, 16'h0000, 11'h000, 1'b0, 16'h1234);
    step();
    idle();
    chk("t4_redirect", {15'd0, last_redirect}, 16'd1);
    step(); step();
    chk("t4_held", imem_addr, 16'h000E);
    d_imem_valid = 1; d_imem_data = 16'hDEAD;
    step();
    d_imem_valid = 0;
    chk("t4_dropped", {15'd0, inst_valid}, 16'd0);
    chk("t4_addr", imem_addr, 16'h1234);
    d_imem_valid = 1; d_imem_data = 16'h2222;
    step();
    d_imem_valid = 0;
    chk("t4_pc2", inst_pc2, 16'h1236);
    d_inst_ready = 1;
    step();
    d_inst_ready = 0;

    set_ex(T_BNEZ, 16'h0004, 11'h080, 1'b0, 16'h0000);
    step();
    chk("t5_not_taken", {15'd0, last_redirect}, 16'd0);
    set_ex(T_BNEZ, 16'h0004, 11'h080, 1'b1, 16'h0000);
    step();
    idle();
    chk("t5_taken", {15'd0, last_redirect}, 16'd1);
    d_imem_valid = 1; d_imem_data = 16'hBEEF;
    step();
    d_imem_valid = 0;
    chk("t5_addr", imem_addr, 16'hFF84);

    set_ex(T_HALT, 16'h0000, 11'h000, 1'b0, 16'h0000);
    step();
    idle();
    repeat (20) begin
      d_imem_valid = 1'($urandom_range(0, 1)); d_inst_ready = 1;
      step();
      chk("t6_halted", {15'd0, halted}, 16'd1);
      chk("t6_req", {15'd0, imem_req}, 16'd0);
    end

    idle();
    d_rst_n = 0; step();
    d_rst_n = 1; step();
    d_imem_valid = 1; d_imem_data = 16'h5555; step();
    d_imem_valid = 0; d_inst_ready = 1; step();
    d_inst_ready = 0;
    #2;
    rst_n = 0; d_rst_n = 0;
    #1;
    model_reset();
    chk("t6_rst_req", {15'd0, imem_req}, 16'd0);
    chk("t6_rst_addr", imem_addr, 16'h0000);
    chk("t6_rst_inst", inst, 16'h0000);
    chk("t6_rst_pc2", inst_pc2, 16'h0002);
    step();
    d_rst_n = 1;
    step();
    chk("t6_refetch", imem_addr, 16'h0000);
    chk("t6_refetch_req", {15'd0, imem_req}, 16'd1);

    stop_cycles = 0;
    for (int i = 0; i < 4000; i++) begin
      stop_cycles = (m_phase == P_STOP) ? stop_cycles + 1 : 0;
      d_rst_n      = !(stop_cycles > 4 || $urandom_range(0, 399) == 0);
      d_imem_valid = ($urandom_range(0, 9) < 4);
      d_imem_data  = 16'($urandom);
      d_inst_ready = ($urandom_range(0, 3) != 0);
      d_ex_valid   = ($urandom_range(0, 9) < 2);
      case ($urandom_range(0, 9))
        0: d_ex_opcode = T_J;
        1: d_ex_opcode = T_JR;
        2: d_ex_opcode = T_JAL;
        3: d_ex_opcode = T_JALR;
        4, 5: d_ex_opcode = {3'b011, 2'($urandom)};
        6: d_ex_opcode = ($urandom_range(0, 5) == 0) ? T_HALT : 5'b00010;
        default: d_ex_opcode = {1'b1, 4'($urandom)};
      endcase
      d_ex_pc2  = 16'($urandom);
      d_ex_imm  = 11'($urandom);
      d_ex_flag = 1'($urandom);
      d_ex_jump = 16'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
